uart_rx_deserializer: RTL and testbench

//  Serial-command receive front end. Oversamples the async RX line, frames 8N1 bytes
//  (start, 8 data LSB-first, stop) and hands each good byte to the command processor
//  as rxData plus a one-cycle rxReady strobe. Flags bad stop bits and overruns.

---
 rtl/uart_rx_deserializer.sv | 132 +++++++++++++
 tb/tb_uart_rx_deserializer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receive front end: synchronises the RX line, samples each bit at its centre
// and presents good bytes as rxData with a one-cycle rxReady strobe.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  input  logic       rx_consumed,
  input  logic       clr_overrun,
  output logic       rxReady,
  output logic [7:0] rxData,
  output logic       frame_error,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t              state, state_n;
  logic [TICK_W-1:0]   tick, tick_n;
  logic [2:0]          bit_idx, bit_n;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic [7:0]          shreg;
  logic                rx_s;
  logic                shift_en;
  logic                ready_n;
  logic                ferr_n;
  logic                pending;

  // Stage p0: synchroniser chain, idles high so reset never looks like a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_p0 <= '1;
    else       sync_p0 <= {sync_p0[SYNC_STAGES-2:0], rx_serial};
  end

  assign rx_s    = sync_p0[SYNC_STAGES-1];
  assign rx_busy = (state != IDLE);

  always_comb begin
    state_n  = state;
    tick_n   = tick + 1'b1;
    bit_n    = bit_idx;
    shift_en = 1'b0;
    ready_n  = 1'b0;
    ferr_n   = 1'b0;
    case (state)
      IDLE: begin
        tick_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (tick == HALF_LAST) begin
          tick_n = '0;
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            bit_n   = 3'd0;
          end
        end
      end
      DATA: begin
        if (tick == FULL_LAST) begin
          tick_n   = '0;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (tick == FULL_LAST) begin
          tick_n  = '0;
          ready_n = rx_s;
          ferr_n  = !rx_s;
          state_n = rx_s ? IDLE : BRK;
        end
      end
      BRK: begin
        // Hold off start detection until the line break ends
        tick_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        tick_n  = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tick        <= '0;
      bit_idx     <= 3'd0;
      rxReady     <= 1'b0;
      frame_error <= 1'b0;
      rxData      <= 8'h00;
    end else begin
      state       <= state_n;
      tick        <= tick_n;
      bit_idx     <= bit_n;
      rxReady     <= ready_n;
      frame_error <= ferr_n;
      if (ready_n) rxData <= shreg;
    end
  end

  // Stage p1: LSB-first shift register, data only
  always_ff @(posedge clk) begin
    if (shift_en) shreg <= {rx_s, shreg[7:1]};
  end

  // A consume landing with a fresh strobe retires the older byte; the new one stays pending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (rxReady)          pending <= 1'b1;
      else if (rx_consumed) pending <= 1'b0;
      if (rxReady && pending && !rx_consumed) overrun <= 1'b1;
      else if (clr_overrun)                   overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed and randomized 8N1 frames against a byte-level reference model of
// the receiver's strobes, held data, pending and overrun behaviour.
module tb_uart_rx_deserializer;

  localparam int CPB  = 16;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_serial;
  logic       rx_consumed;
  logic       clr_overrun;
  logic       rxReady;
  logic [7:0] rxData;
  logic       frame_error;
  logic       overrun;
  logic       rx_busy;

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .rx_serial(rx_serial), .rx_consumed(rx_consumed),
    .clr_overrun(clr_overrun), .rxReady(rxReady), .rxData(rxData),
    .frame_error(frame_error), .overrun(overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;
  int ready_cyc = 0;
  int ferr_cnt  = 0;
  logic prev_strobe = 1'b0;
  logic [7:0] got_q[$];

  // reference model state
  logic [7:0] last_m = 8'h00;
  logic       pend_m = 1'b0;
  logic       ovr_m  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rxReady === 1'b1) begin
      got_q.push_back(rxData);
      ready_cyc = cyc;
    end
    if (frame_error === 1'b1) ferr_cnt++;
    if (rxReady === 1'b1 || frame_error === 1'b1) begin
      total++;
      assert (!(rxReady === 1'b1 && frame_error === 1'b1) && !prev_strobe) else begin
        bad++;
        $error("FAIL strobe_excl: observed ready=%b ferr=%b prev=%b required isolated single strobe",
               rxReady, frame_error, prev_strobe);
      end
    end
    prev_strobe = (rxReady === 1'b1) || (frame_error === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic consume);
    logic [8:0] bits;
    logic saw;
    bits = {b, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 9; i++) begin
      rx_serial = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx_serial = stop;
    saw = 1'b0;
    for (int c = 0; c < CPB; c++) begin
      rx_consumed = consume && saw;
      saw = (rxReady === 1'b1);
      @(negedge clk);
    end
    rx_consumed = 1'b0;
  endtask

  // Send one frame, advance the model, and compare everything observable
  task automatic frame_check(input string tag, input logic [7:0] b, input logic stop,
                             input logic consume);
    send_frame(b, stop, consume);
    if (stop) begin
      if (pend_m) ovr_m = 1'b1;
      pend_m = !consume;
      last_m = b;
    end
    chk({tag, "_nready"}, got_q.size(), stop ? 1 : 0);
    if (got_q.size() > 0) chk({tag, "_data"}, got_q.pop_front(), b);
    chk({tag, "_ferr"}, ferr_cnt, stop ? 0 : 1);
    chk({tag, "_rxData"}, rxData, last_m);
    chk({tag, "_ovr"}, overrun, ovr_m);
    got_q.delete();
    ferr_cnt = 0;
  endtask

  initial begin
    reset = 1'b1;
    rx_serial = 1'b1;
    rx_consumed = 1'b0;
    clr_overrun = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", rxReady, 1'b0);
    chk("rst_data", rxData, 8'h00);
    chk("rst_ferr", frame_error, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_busy", rx_busy, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // single byte with latency
    frame_check("a5", 8'hA5, 1'b1, 1'b1);
    chk("a5_latency", ready_cyc - start_cyc, (19 * CPB) / 2 + SYNC + 1);
    repeat (4) @(negedge clk);

    // back-to-back frames
    frame_check("b2b0", 8'h00, 1'b1, 1'b1);
    frame_check("b2b1", 8'hFF, 1'b1, 1'b1);
    frame_check("b2b2", 8'h0A, 1'b1, 1'b1);
    repeat (4) @(negedge clk);

    // short low glitch
    rx_serial = 1'b0;
    repeat (5) @(negedge clk);
    rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    chk("glitch_busy", rx_busy, 1'b1);
    repeat (30) @(negedge clk);
    chk("glitch_idle", rx_busy, 1'b0);
    chk("glitch_nready", got_q.size(), 0);
    chk("glitch_ferr", ferr_cnt, 0);

    // stop bit low, line break, then recovery
    frame_check("brk", 8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    chk("brk_busy", rx_busy, 1'b1);
    rx_serial = 1'b1;
    repeat (5) @(negedge clk);
    chk("brk_idle", rx_busy, 1'b0);
    frame_check("after_brk", 8'h11, 1'b1, 1'b1);
    repeat (4) @(negedge clk);

    // overrun and its clear
    frame_check("ovr1", 8'h5A, 1'b1, 1'b0);
    frame_check("ovr2", 8'hC3, 1'b1, 1'b0);
    chk("ovr_set", overrun, 1'b1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    ovr_m = 1'b0;
    chk("ovr_clr", overrun, 1'b0);
    rx_consumed = 1'b1;
    @(negedge clk);
    rx_consumed = 1'b0;
    pend_m = 1'b0;
    repeat (4) @(negedge clk);

    // reset during data bit 4 of 0x77
    rx_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_serial = (8'h77 >> i) & 1;
      repeat (CPB) @(negedge clk);
    end
    rx_serial = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    chk("mid_busy", rx_busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_data", rxData, 8'h00);
    chk("mid_rst_busy", rx_busy, 1'b0);
    chk("mid_rst_ready", rxReady, 1'b0);
    chk("mid_rst_ovr", overrun, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_m = 8'h00; pend_m = 1'b0; ovr_m = 1'b0;
    repeat (CPB * 10) @(negedge clk);
    chk("post_rst_nready", got_q.size(), 0);
    got_q.delete();
    ferr_cnt = 0;
    frame_check("post_rst", 8'h42, 1'b1, 1'b1);

    // randomized frames
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      logic stop, cons;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      cons = ($urandom_range(0, 3) != 0);
      frame_check("rnd", b, stop, cons);
      if (!stop) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        rx_serial = 1'b1;
        repeat ($urandom_range(2, 10)) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
      if (ovr_m && $urandom_range(0, 1) == 1) begin
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        ovr_m = 1'b0;
        chk("rnd_clr", overrun, 1'b0);
      end
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
